// File: rtl/pb_event_arbiter.sv
// Shared-tick pushbutton debouncer feeding a round-robin event arbiter.
// Debounced presses queue as pending bits and leave one at a time on a valid/ready port.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  S_IDLE    | no event presented; grants the next pending press round-robin
//  S_PRESENT | evt_valid/evt_id held until the consumer raises evt_ready
module pb_event_arbiter #(
    parameter int N_PB       = 4,
    parameter int SAMPLE_DIV = 100000,
    parameter int WIN        = 4,
    localparam int ID_W      = $clog2(N_PB)
) (
    input  logic            clk_100,
    input  logic            rst,
    input  logic [N_PB-1:0] pb_raw,
    output logic [N_PB-1:0] pb_level,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    input  logic            evt_ready,
    output logic            overflow
);

    localparam int              CNT_W    = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [ID_W-1:0]  RR_INIT  = ID_W'(N_PB - 1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [WIN-1:0]   win     [N_PB];
    logic [WIN-1:0]   win_new [N_PB];
    logic [N_PB-1:0]  pb_level_d;
    logic [N_PB-1:0]  pb_rise;
    logic [N_PB-1:0]  pending;
    logic [N_PB-1:0]  pend_clr;
    logic [N_PB-1:0]  pend_next;
    logic             ovf_set;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_idx;
    logic [ID_W-1:0]  grant;
    logic             grant_ok;
    logic [0:0]       state;

    assign tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge clk_100) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_PB; i++) begin
            win_new[i] = {win[i][WIN-2:0], pb_raw[i]};
        end
    end

    // A mixed window holds the previous level, giving hysteresis against bounce.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            for (int i = 0; i < N_PB; i++) begin
                win[i] <= '0;
            end
            pb_level   <= '0;
            pb_level_d <= '0;
        end else begin
            pb_level_d <= pb_level;
            if (tick) begin
                for (int i = 0; i < N_PB; i++) begin
                    win[i] <= win_new[i];
                    if (&win_new[i]) begin
                        pb_level[i] <= 1'b1;
                    end else if (~|win_new[i]) begin
                        pb_level[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= N_PB; k++) begin
            rr_idx = ID_W'((int'(rr_ptr) + k) % N_PB);
            if (!grant_ok && pending[rr_idx]) begin
                grant_ok = 1'b1;
                grant    = rr_idx;
            end
        end
    end

    // A new press on a bit being granted this cycle re-arms it without counting as lost.
    always_comb begin
        pend_clr = '0;
        if (state == S_IDLE && grant_ok) begin
            pend_clr[grant] = 1'b1;
        end
        pb_rise   = pb_level & ~pb_level_d;
        pend_next = (pending & ~pend_clr) | pb_rise;
        ovf_set   = |(pb_rise & pending & ~pend_clr);
    end

    always_ff @(posedge clk_100) begin
        if (rst) begin
            state     <= S_IDLE;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_ptr    <= RR_INIT;
            pending   <= '0;
            overflow  <= 1'b0;
        end else begin
            pending <= pend_next;
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (grant_ok) begin
                        evt_valid <= 1'b1;
                        evt_id    <= grant;
                        state     <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        rr_ptr    <= evt_id;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Bench for pb_event_arbiter: random button activity against a sample-history model,
// then directed press scenarios with fixed expected event orders.
module tb_pb_event_arbiter;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int W  = 4;

    logic       clk_100 = 1'b0;
    logic       rst;
    logic [3:0] pb_raw;
    logic [3:0] pb_level;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the sample stream is tracked as the latest value plus how
    // many consecutive samples have shown it.
    int       m_cnt;
    int       m_run [N];
    bit [3:0] m_last;
    bit [3:0] m_level, m_level_d, m_pend;
    bit       m_valid, m_ovf;
    int       m_id, m_rr;

    int acc_q[$];

    pb_event_arbiter #(.N_PB(N), .SAMPLE_DIV(SD), .WIN(W)) dut (
        .clk_100  (clk_100),
        .rst      (rst),
        .pb_raw   (pb_raw),
        .pb_level (pb_level),
        .evt_valid(evt_valid),
        .evt_id   (evt_id),
        .evt_ready(evt_ready),
        .overflow (overflow)
    );

    initial forever #5 clk_100 = ~clk_100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [3:0] raw, input logic rdy);
        bit [3:0] lvl, lvl_d, pend, rise, clr;
        bit       found;
        int       j;
        if (r) begin
            m_cnt = 0;
            for (int i = 0; i < N; i++) m_run[i] = W;
            m_last = '0; m_level = '0; m_level_d = '0; m_pend = '0;
            m_valid = 0; m_id = 0; m_rr = N - 1; m_ovf = 0;
            return;
        end
        lvl = m_level; lvl_d = m_level_d; pend = m_pend; clr = '0;
        rise = lvl & ~lvl_d;
        m_level_d = lvl;
        if (m_cnt == SD - 1) begin
            for (int i = 0; i < N; i++) begin
                if (raw[i] == m_last[i]) begin
                    if (m_run[i] < W) m_run[i]++;
                end else begin
                    m_last[i] = raw[i];
                    m_run[i]  = 1;
                end
                if (m_run[i] >= W) m_level[i] = m_last[i];
            end
        end
        m_cnt = (m_cnt + 1) % SD;
        if (!m_valid) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                j = (m_rr + k) % N;
                if (!found && pend[j]) begin
                    found = 1; m_valid = 1; m_id = j; clr[j] = 1'b1;
                end
            end
        end else if (rdy) begin
            m_valid = 0;
            m_rr = m_id;
        end
        if ((rise & pend & ~clr) != 0) m_ovf = 1;
        m_pend = (pend & ~clr) | rise;
    endtask

    task automatic cycle();
        if (evt_valid && evt_ready && !rst) acc_q.push_back(int'(evt_id));
        @(posedge clk_100);
        model_edge(rst, pb_raw, evt_ready);
        #1;
        check("pb_level",  pb_level,  m_level);
        check("evt_valid", evt_valid, m_valid);
        check("evt_id",    evt_id,    m_id);
        check("overflow",  overflow,  m_ovf);
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        check("rst_level",    pb_level,  0);
        check("rst_valid",    evt_valid, 0);
        check("rst_id",       evt_id,    0);
        check("rst_overflow", overflow,  0);
        rst = 1'b0;
        acc_q.delete();
    endtask

    task automatic check_seq(input string tag, input int exp[$]);
        check({tag, "_count"}, acc_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < acc_q.size(); i++)
            check(tag, acc_q[i], exp[i]);
    endtask

    initial begin
        rst = 1'b1; pb_raw = '0; evt_ready = 1'b0;
        do_reset(2);

        // random button activity with changing consumer back-pressure
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 500; c++) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 39) == 0) pb_raw[i] = ~pb_raw[i];
                evt_ready = ($urandom_range(0, 3) < ((seg % 2 == 0) ? 1 : 3));
                cycle();
            end
        end

        // mid-run reset, then steady press on button 2
        evt_ready = 1'b0;
        do_reset(3);
        pb_raw = 4'b0100;
        run(15);
        check("t2_level_early", pb_level, 4'b0000);
        run(1);
        check("t2_level_rise", pb_level, 4'b0100);
        run(1);
        check("t2_valid_early", evt_valid, 0);
        run(1);
        check("t2_valid", evt_valid, 1);
        check("t2_id", evt_id, 2);
        evt_ready = 1'b1;
        run(1);
        check("t2_valid_drop", evt_valid, 0);
        check_seq("t2_seq", '{2});

        // bouncing button 1
        do_reset(3);
        evt_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            pb_raw = (t % 2 == 0) ? 4'b0010 : 4'b0000;
            run(SD);
        end
        run(4);
        check("t3_level", pb_level, 0);
        check("t3_events", acc_q.size(), 0);

        // simultaneous presses on 0, 1, 3
        do_reset(3);
        evt_ready = 1'b1;
        pb_raw = 4'b1011;
        run(6 * SD);
        check_seq("t4_seq", '{0, 1, 3});

        // stalled consumer with repeated presses on button 0
        do_reset(3);
        evt_ready = 1'b0;
        pb_raw = 4'b0001; run(5 * SD);
        check("t5_valid1", evt_valid, 1);
        check("t5_id1", evt_id, 0);
        pb_raw = 4'b0000; run(5 * SD);
        pb_raw = 4'b0001; run(5 * SD);
        check("t5_ovf_second", overflow, 0);
        check("t5_valid2", evt_valid, 1);
        pb_raw = 4'b0000; run(5 * SD);
        pb_raw = 4'b0001; run(5 * SD);
        check("t5_ovf_third", overflow, 1);
        pb_raw = 4'b0000;
        evt_ready = 1'b1;
        run(10);
        check_seq("t5_seq", '{0, 0});
        check("t5_valid_end", evt_valid, 0);

        // round-robin after button 3 was served
        do_reset(3);
        evt_ready = 1'b1;
        pb_raw = 4'b1000; run(5 * SD);
        pb_raw = 4'b0000; run(5 * SD);
        pb_raw = 4'b1001; run(6 * SD);
        check_seq("t6_seq", '{3, 0, 3});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
